// File: rtl/logicnet_pkg.sv
`default_nettype none
// ============================================================================
// Module : logicnet_pkg
// Brief  : Shared types, constants and slot helper for the LogicNet input stage.
// Rev    : 1.0
// ============================================================================
package logicnet_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int QCODE_W = 2;

    function automatic int slot_off(input int k);
        return k * QCODE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logicnet_thresh_quant.sv
`default_nettype none
// ============================================================================
// Module : logicnet_thresh_quant
// Brief  : Three-threshold quantizer, unsigned input to a 2-bit code.
// Rev    : 1.0
// ============================================================================
module logicnet_thresh_quant
    import logicnet_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int T0   = 64,
    parameter int T1   = 128,
    parameter int T2   = 192
) (
    input  logic [IN_W-1:0]    i_data,
    output logic [QCODE_W-1:0] o_code
);

    localparam logic [IN_W-1:0] c_T0 = IN_W'(T0);
    localparam logic [IN_W-1:0] c_T1 = IN_W'(T1);
    localparam logic [IN_W-1:0] c_T2 = IN_W'(T2);

    logic w_ge0;
    logic w_ge1;
    logic w_ge2;

    // Equality counts as having crossed the threshold.
    assign w_ge0 = (i_data >= c_T0);
    assign w_ge1 = (i_data >= c_T1);
    assign w_ge2 = (i_data >= c_T2);

    assign o_code = {1'b0, w_ge0} + {1'b0, w_ge1} + {1'b0, w_ge2};

endmodule
`default_nettype wire

// File: rtl/logicnet_input_packer.sv
`default_nettype none
// ============================================================================
// Module : logicnet_input_packer
// Brief  : Quantizes raw feature beats and packs them, double-buffered, into
//          one flat input vector for the layer-0 LUT neurons.
// Rev    : 1.0
// ============================================================================
module logicnet_input_packer
    import logicnet_pkg::*;
#(
    parameter int NUM_FEATURES = 49,
    parameter int IN_W         = 8,
    parameter int BITS         = QCODE_W,
    parameter int T0           = 64,
    parameter int T1           = 128,
    parameter int T2           = 192,
    parameter int CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [IN_W-1:0]              s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_FEATURES*BITS-1:0] m_data,
    output logic                         err,
    output logic [CNT_W-1:0]             vec_count
);

    localparam int              c_IDX_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int              c_VEC_W    = NUM_FEATURES * BITS;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_FEATURES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_s_ready;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_VEC_W-1:0]   r_asm;
    logic [c_VEC_W-1:0]   w_asm_merged;
    logic [c_VEC_W-1:0]   w_xfer_data;
    logic                 r_m_valid;
    logic [c_VEC_W-1:0]   r_m_data;
    logic                 r_err;
    logic [CNT_W-1:0]     r_vec_count;
    logic [QCODE_W-1:0]   w_code;

    logic w_accept;
    logic w_at_last;
    logic w_out_free;
    logic w_xfer;
    logic w_asm_clr;
    logic w_asm_wr;
    logic w_idx_inc;
    logic w_err_next;

    logicnet_thresh_quant #(
        .IN_W (IN_W),
        .T0   (T0),
        .T1   (T1),
        .T2   (T2)
    ) u_quant (
        .i_data (s_data),
        .o_code (w_code)
    );

    assign w_accept   = s_valid && r_s_ready;
    assign w_at_last  = (r_idx == c_LAST_IDX);
    assign w_out_free = !r_m_valid || m_ready;

    // Assembly image with the in-flight code merged in, so a completing beat
    // can go straight to the output register in the same cycle.
    always_comb begin
        w_asm_merged = r_asm;
        w_asm_merged[slot_off(int'(r_idx)) +: QCODE_W] = w_code;
    end

    assign w_xfer_data = (r_state == FILL) ? w_asm_merged : r_asm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        w_asm_clr    = 1'b0;
        w_asm_wr     = 1'b0;
        w_idx_inc    = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (w_at_last) begin
                        w_err_next = !s_last;
                        if (w_out_free) begin
                            w_xfer    = 1'b1;
                            w_asm_clr = 1'b1;
                        end else begin
                            w_asm_wr     = 1'b1;
                            w_state_next = HOLD;
                        end
                    end else if (s_last) begin
                        w_err_next = 1'b1;
                        w_asm_clr  = 1'b1;
                    end else begin
                        w_asm_wr  = 1'b1;
                        w_idx_inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (r_m_valid && m_ready) begin
                    w_xfer       = 1'b1;
                    w_asm_clr    = 1'b1;
                    w_state_next = FILL;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    // s_ready is registered from the next state, keeping m_ready off any
    // combinational path to the upstream handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_ready <= 1'b0;
            r_idx     <= '0;
            r_asm     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_s_ready <= (w_state_next == FILL);
            r_err     <= w_err_next;
            if (w_asm_clr) begin
                r_asm <= '0;
                r_idx <= '0;
            end else begin
                if (w_asm_wr) begin
                    r_asm[slot_off(int'(r_idx)) +: QCODE_W] <= w_code;
                end
                if (w_idx_inc) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_vec_count <= '0;
        end else begin
            if (w_xfer) begin
                r_m_valid   <= 1'b1;
                r_m_data    <= w_xfer_data;
                r_vec_count <= r_vec_count + 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign err       = r_err;
    assign vec_count = r_vec_count;

endmodule
`default_nettype wire

// File: tb/tb_logicnet_input_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_logicnet_input_packer
// Brief  : Directed vector bench for logicnet_input_packer (3 features).
// Rev    : 1.0
// ============================================================================
module tb_logicnet_input_packer;

    localparam int c_NF    = 3;
    localparam int c_IN_W  = 8;
    localparam int c_CNT_W = 16;

    logic                clk;
    logic                rst;
    logic                s_valid;
    logic                s_ready;
    logic [c_IN_W-1:0]   s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [c_NF*2-1:0]   m_data;
    logic                err;
    logic [c_CNT_W-1:0]  vec_count;

    int n_checks;
    int n_errors;
    int exp_cnt;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       last3;
        logic [5:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t tbl [5];

    logicnet_input_packer #(
        .NUM_FEATURES (c_NF),
        .IN_W         (c_IN_W),
        .BITS         (2),
        .T0           (64),
        .T1           (128),
        .T2           (192),
        .CNT_W        (c_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err       (err),
        .vec_count (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        while (!s_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b1;
        s_data  = 8'hA5;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b1;

        tbl[0] = '{d0: 8'd10,  d1: 8'd130, d2: 8'd200, last3: 1'b1, exp_data: 6'b111000, exp_err: 1'b0};
        tbl[1] = '{d0: 8'd63,  d1: 8'd64,  d2: 8'd192, last3: 1'b1, exp_data: 6'b110100, exp_err: 1'b0};
        tbl[2] = '{d0: 8'd255, d1: 8'd255, d2: 8'd255, last3: 1'b0, exp_data: 6'b111111, exp_err: 1'b1};
        tbl[3] = '{d0: 8'd70,  d1: 8'd70,  d2: 8'd70,  last3: 1'b1, exp_data: 6'b010101, exp_err: 1'b0};
        tbl[4] = '{d0: 8'd0,   d1: 8'd127, d2: 8'd191, last3: 1'b1, exp_data: 6'b100100, exp_err: 1'b0};

        // Reset state
        #2;
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_err", 32'(err), 0);
        check("rst_vec_count", 32'(vec_count), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_s_ready", 32'(s_ready), 1);

        // Table: one 3-beat vector each, m_ready held high
        for (int i = 0; i < 5; i++) begin
            send_beat(tbl[i].d0, 1'b0);
            send_beat(tbl[i].d1, 1'b0);
            send_beat(tbl[i].d2, tbl[i].last3);
            exp_cnt++;
            check($sformatf("v%0d_m_valid", i), 32'(m_valid), 1);
            check($sformatf("v%0d_m_data", i), 32'(m_data), 32'(tbl[i].exp_data));
            check($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("v%0d_vec_count", i), 32'(vec_count), 32'(exp_cnt));
            tick();
            check($sformatf("v%0d_m_valid_clr", i), 32'(m_valid), 0);
            check($sformatf("v%0d_err_clr", i), 32'(err), 0);
        end

        // Backpressure: second vector completes while first is held
        m_ready = 1'b0;
        send_beat(8'd255, 1'b0);
        send_beat(8'd0, 1'b0);
        send_beat(8'd128, 1'b1);
        exp_cnt++;
        check("bp_first_valid", 32'(m_valid), 1);
        check("bp_first_data", 32'(m_data), 32'(6'b100011));
        send_beat(8'd0, 1'b0);
        send_beat(8'd0, 1'b0);
        send_beat(8'd0, 1'b1);
        check("bp_hold_s_ready", 32'(s_ready), 0);
        check("bp_hold_data", 32'(m_data), 32'(6'b100011));
        tick();
        tick();
        check("bp_hold_stable_data", 32'(m_data), 32'(6'b100011));
        check("bp_hold_stable_valid", 32'(m_valid), 1);
        check("bp_hold_vec_count", 32'(vec_count), 32'(exp_cnt));
        m_ready = 1'b1;
        tick();
        exp_cnt++;
        check("bp_second_valid", 32'(m_valid), 1);
        check("bp_second_data", 32'(m_data), 32'(6'b000000));
        check("bp_s_ready_back", 32'(s_ready), 1);
        check("bp_vec_count", 32'(vec_count), 32'(exp_cnt));
        tick();
        check("bp_drain", 32'(m_valid), 0);

        // Early s_last: partial vector dropped
        send_beat(8'd200, 1'b0);
        send_beat(8'd100, 1'b1);
        check("early_err", 32'(err), 1);
        check("early_no_valid", 32'(m_valid), 0);
        check("early_vec_count", 32'(vec_count), 32'(exp_cnt));
        tick();
        check("early_err_clr", 32'(err), 0);
        send_beat(8'd1, 1'b0);
        send_beat(8'd1, 1'b0);
        send_beat(8'd1, 1'b1);
        exp_cnt++;
        check("early_next_valid", 32'(m_valid), 1);
        check("early_next_data", 32'(m_data), 32'(6'b000000));
        check("early_next_err", 32'(err), 0);
        check("early_next_vec_count", 32'(vec_count), 32'(exp_cnt));
        tick();

        // Asynchronous reset with a held output and a partial vector in flight
        m_ready = 1'b0;
        send_beat(8'd255, 1'b0);
        send_beat(8'd255, 1'b0);
        send_beat(8'd255, 1'b1);
        send_beat(8'd200, 1'b0);
        send_beat(8'd200, 1'b0);
        check("mid_held_valid", 32'(m_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        check("mid_rst_m_valid", 32'(m_valid), 0);
        check("mid_rst_s_ready", 32'(s_ready), 0);
        check("mid_rst_vec_count", 32'(vec_count), 0);
        check("mid_rst_m_data", 32'(m_data), 0);
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        tick();
        check("mid_post_s_ready", 32'(s_ready), 1);
        send_beat(8'd70, 1'b0);
        send_beat(8'd70, 1'b0);
        send_beat(8'd70, 1'b1);
        exp_cnt++;
        check("mid_post_valid", 32'(m_valid), 1);
        check("mid_post_data", 32'(m_data), 32'(6'b010101));
        check("mid_post_err", 32'(err), 0);
        check("mid_post_vec_count", 32'(vec_count), 32'(exp_cnt));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logicnet_input_packer.md
Name: logicnet_input_packer

Overview:
- Ingest stage directly upstream of the layer-0 LUT neurons.
- Accepts raw feature words one per beat over a valid/ready stream and quantizes each to a BITS-wide code against three global thresholds.
- Packs NUM_FEATURES codes into one flat input vector and presents it, registered, to layer 0 over a valid/ready handshake.
- Double-buffered: assembly of vector N+1 overlaps hold of vector N.

Parameters:
- NUM_FEATURES, 49, features per input vector (>=2)
- IN_W, 8, raw feature width, unsigned
- BITS, 2, code width; fixed at 2 by the three-threshold quantizer
- T0, 64, lowest threshold (unsigned IN_W)
- T1, 128, middle threshold; T0<T1<T2 required
- T2, 192, highest threshold
- CNT_W, 16, width of completed-vector counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- s_valid  in  1  raw feature beat valid
- s_ready  out  1  packer accepts beat
- s_data  in  IN_W  raw feature value, unsigned
- s_last  in  1  marks final feature of a vector
- m_valid  out  1  packed vector valid to layer 0
- m_ready  in  1  layer 0 accepts vector
- m_data  out  NUM_FEATURES*BITS  packed codes; feature k at [k*BITS +: BITS], feature 0 in LSBs
- err  out  1  one-cycle framing-error pulse
- vec_count  out  CNT_W  completed vectors transferred to output register

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
- Reset values: s_ready=0 during reset, 1 the first cycle after; m_valid=0, m_data=0, err=0, vec_count=0, idx=0, state=FILL, assembly register=0.
- Reset mid-vector discards partial vector and held output with no error.
- Quantizer (combinational on s_data): code = (s_data>=T0)+(s_data>=T1)+(s_data>=T2), giving 0..3. Equality counts as exceeded.
- Beat accepted when s_valid && s_ready. Code written to assembly slot idx; idx increments.
- States:
  - FILL: s_ready=1. Accepting idx==NUM_FEATURES-1 completes the vector:
    - If output register empty or m_ready this cycle: copy assembly (with final code merged) to m_data, set m_valid, clear assembly, idx=0, stay FILL.
    - Else go HOLD.
  - HOLD: s_ready=0. When m_valid && m_ready: transfer assembly to m_data, m_valid stays 1, idx=0, go FILL. s_ready returns the next cycle.
- Output handshake: m_valid && m_ready clears m_valid unless a transfer occurs the same cycle. m_data is stable while m_valid && !m_ready.
- Latency: last beat accepted at cycle n -> m_valid=1 at n+1 when output is free. Sustained throughput 1 feature/cycle when m_ready=1.
- vec_count increments on every assembly->output transfer; wraps modulo 2^CNT_W.
- Framing rules:
  - s_last accepted with idx<NUM_FEATURES-1: partial vector dropped, assembly cleared, idx=0, err=1 next cycle, no transfer, vec_count unchanged.
  - idx==NUM_FEATURES-1 accepted with s_last=0: vector still completes normally and err=1 next cycle.
  - Both errors are never simultaneous. err is a single-cycle pulse per offending beat.
- s_data/s_last are ignored when not accepted. No combinational path from m_ready to s_ready in FILL; in HOLD s_ready depends on registered state only.

Decomposition:
- Shared package logicnet_pkg:
  - state enum {FILL, HOLD}
  - quantizer code width constant (2)
  - function for slot offset k*BITS
- One natural sub-module: logicnet_thresh_quant (IN_W, T0..T2 -> 2-bit code), reusable by other input stages.
- Packer top holds counter, FSM, and both registers.

Test Plan (NUM_FEATURES=3, IN_W=8, T0=64, T1=128, T2=192 unless stated):
- Basic pack: beats 10,130,200 (last on 3rd), m_ready=1 -> m_valid one cycle after beat 3, m_data=6'b111000, vec_count=1, err=0.
- Threshold edges: beats 63,64,192 -> codes 0,1,3 -> m_data=6'b110100.
- Backpressure: m_ready=0, send two vectors (255,0,128 then 0,0,0):
  - First held with m_data=6'b100011.
  - s_ready drops after the 6th beat (HOLD).
  - Raise m_ready -> first consumed, m_data=6'b000000 valid, s_ready=1 next cycle, vec_count=2.
- Early last: beats 200,(s_last)100 -> err pulse one cycle, no m_valid. Then 1,1,1 -> m_data=6'b000000, vec_count=1.
- Missing last: 3 beats of 255, none with s_last -> m_data=6'b111111 emitted, err pulse one cycle after 3rd beat.
- Reset mid-vector: after 2 beats assert rst asynchronously between edges -> m_valid=0, s_ready=0 immediately, vec_count=0. After release, 70,70,70 -> m_data=6'b010101.
